// File: rtl/axi_write_arbiter_if.sv
// Requester-side and write-master-side signals of the shared single-beat write arbiter.
// The arbiter uses the slave modport; the environment driving requests and the write master uses master.
interface axi_write_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_waddr;
  logic [NUM_REQ*32-1:0]         req_wdata;
  logic [NUM_REQ*4-1:0]          req_wstrb;
  logic [NUM_REQ-1:0]            req_pending;
  logic [NUM_REQ-1:0]            req_done;
  logic [1:0]                    req_resp;
  logic [NUM_REQ-1:0]            req_overflow;
  logic                          overflow_clr;
  logic [ADDR_WIDTH-1:0]         m_axi_waddr;
  logic [31:0]                   m_axi_wdata;
  logic [3:0]                    m_axi_wstrb;
  logic                          m_axi_write;
  logic                          m_axi_write_busy;
  logic                          m_axi_write_failed;
  logic                          m_axi_write_timeout;
  logic                          arb_active;

  modport slave (
    input  req_write, req_waddr, req_wdata, req_wstrb, overflow_clr,
    input  m_axi_write_busy, m_axi_write_failed, m_axi_write_timeout,
    output req_pending, req_done, req_resp, req_overflow,
    output m_axi_waddr, m_axi_wdata, m_axi_wstrb, m_axi_write, arb_active
  );

  modport master (
    output req_write, req_waddr, req_wdata, req_wstrb, overflow_clr,
    output m_axi_write_busy, m_axi_write_failed, m_axi_write_timeout,
    input  req_pending, req_done, req_resp, req_overflow,
    input  m_axi_waddr, m_axi_wdata, m_axi_wstrb, m_axi_write, arb_active
  );
endinterface

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI write master between NUM_REQ requesters,
// each with a 1-deep command slot; one write in flight, status routed back to the issuer.
module axi_write_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int START_TIMEOUT = 16
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESET,
  axi_write_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;
  localparam int CNT_W = $clog2(START_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  localparam logic [1:0] RESP_OK       = 2'b00;
  localparam logic [1:0] RESP_FAILED   = 2'b01;
  localparam logic [1:0] RESP_TIMEOUT  = 2'b10;
  localparam logic [1:0] RESP_NO_START = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Slot contents gathered from the per-requester generate blocks
  logic [NUM_REQ-1:0]    slot_valid;
  logic [NUM_REQ-1:0]    slot_overflow;
  logic [NUM_REQ-1:0]    slot_clr;
  logic [ADDR_WIDTH-1:0] slot_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] slot_data [NUM_REQ];
  logic [3:0]            slot_strb [NUM_REQ];

  logic [IDX_W-1:0]      rr_ptr_reg;
  logic [IDX_W-1:0]      grant_reg;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      scan_idx;
  logic [SUM_W-1:0]      scan_sum;
  logic                  grant_found;
  logic                  grant_go;
  logic                  finish;
  logic [1:0]            finish_resp;
  logic                  done_hold;
  logic [CNT_W-1:0]      cnt_reg;

  logic [NUM_REQ-1:0]    done_reg;
  logic [1:0]            resp_reg;
  logic [ADDR_WIDTH-1:0] waddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [3:0]            wstrb_reg;
  logic                  write_next;
  logic                  active_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      logic                  valid_reg;
      logic                  overflow_reg;
      logic [ADDR_WIDTH-1:0] addr_reg;
      logic [DATA_WIDTH-1:0] data_reg;
      logic [3:0]            strb_reg;
      logic                  accept;
      logic                  collide;

      assign slot_clr[gi] = finish && (grant_reg == IDX_W'(gi));
      // A slot being emptied this cycle can take a new command without overflowing
      assign accept  = bus.req_write[gi] && (!valid_reg || slot_clr[gi]);
      assign collide = bus.req_write[gi] && valid_reg && !slot_clr[gi];

      always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
          valid_reg    <= 1'b0;
          overflow_reg <= 1'b0;
          addr_reg     <= '0;
          data_reg     <= '0;
          strb_reg     <= '0;
        end else begin
          if (accept) begin
            valid_reg <= 1'b1;
            addr_reg  <= bus.req_waddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            data_reg  <= bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            strb_reg  <= bus.req_wstrb[gi*4 +: 4];
          end else if (slot_clr[gi]) begin
            valid_reg <= 1'b0;
          end
          if (collide) begin
            overflow_reg <= 1'b1;
          end else if (bus.overflow_clr) begin
            overflow_reg <= 1'b0;
          end
        end
      end

      assign slot_valid[gi]    = valid_reg;
      assign slot_overflow[gi] = overflow_reg;
      assign slot_addr[gi]     = addr_reg;
      assign slot_data[gi]     = data_reg;
      assign slot_strb[gi]     = strb_reg;
    end
  endgenerate

  // First pending slot at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_reg} + SUM_W'(k);
      if (scan_sum >= SUM_W'(NUM_REQ)) begin
        scan_sum = scan_sum - SUM_W'(NUM_REQ);
      end
      scan_idx = scan_sum[IDX_W-1:0];
      if (!grant_found && slot_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Holding off while req_done is up puts the next grant one cycle after the pulse
  assign done_hold = |done_reg;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_go    = 1'b0;
    finish      = 1'b0;
    finish_resp = RESP_OK;
    case (state_reg)
      IDLE: begin
        if (grant_found && !done_hold) begin
          grant_go   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.m_axi_write_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt_reg == CNT_LAST) begin
          finish      = 1'b1;
          finish_resp = RESP_NO_START;
          state_next  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!bus.m_axi_write_busy) begin
          finish     = 1'b1;
          state_next = IDLE;
          if (bus.m_axi_write_timeout) begin
            finish_resp = RESP_TIMEOUT;
          end else if (bus.m_axi_write_failed) begin
            finish_resp = RESP_FAILED;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    write_next  = (state_reg == ISSUE);
    active_next = (state_reg != IDLE);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      cnt_reg    <= '0;
      done_reg   <= '0;
      resp_reg   <= RESP_OK;
      waddr_reg  <= '0;
      wdata_reg  <= '0;
      wstrb_reg  <= '0;
    end else begin
      done_reg <= '0;
      resp_reg <= RESP_OK;
      if (finish) begin
        done_reg[grant_reg] <= 1'b1;
        resp_reg            <= finish_resp;
      end
      if (grant_go) begin
        grant_reg  <= grant_idx;
        rr_ptr_reg <= (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
        waddr_reg  <= slot_addr[grant_idx];
        wdata_reg  <= slot_data[grant_idx];
        wstrb_reg  <= slot_strb[grant_idx];
      end
      if (state_reg == ISSUE) begin
        cnt_reg <= '0;
      end else if (state_reg == WAIT_BUSY && !bus.m_axi_write_busy) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign bus.req_pending  = slot_valid;
  assign bus.req_overflow = slot_overflow;
  assign bus.req_done     = done_reg;
  assign bus.req_resp     = resp_reg;
  assign bus.m_axi_waddr  = waddr_reg;
  assign bus.m_axi_wdata  = wdata_reg;
  assign bus.m_axi_wstrb  = wstrb_reg;
  assign bus.m_axi_write  = write_next;
  assign bus.arb_active   = active_next;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Scoreboard bench for axi_write_arbiter: a write-master model answers each issue with a queued
// behaviour, and issued commands and their completions are checked against queued expectations.
module tb_axi_write_arbiter;
  localparam int NUM_REQ       = 2;
  localparam int ADDR_WIDTH    = 32;
  localparam int START_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_write_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  axi_write_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(32), .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESET(rst),
    .bus(bus)
  );

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } issue_t;

  typedef struct {
    int len;      // busy-high cycles; 0 means busy never rises
    bit failed;
    bit timeout;
  } beh_t;

  issue_t exp_q[$];
  beh_t   beh_q[$];
  int     n_checks    = 0;
  int     n_pass      = 0;
  int     write_count = 0;
  int     done_count  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Write-master model plus completion monitor, both evaluated on the falling edge
  initial begin
    int     cyc = 0;
    int     issue_cyc = 0;
    bit     in_flight = 0;
    issue_t cur;
    beh_t   b;
    int     rel = 0;
    bit     rsp_active = 0;
    logic [1:0] exp_resp = 2'b00;
    int     exp_lat = 0;
    bus.m_axi_write_busy    = 1'b0;
    bus.m_axi_write_failed  = 1'b0;
    bus.m_axi_write_timeout = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.m_axi_write) begin
        write_count++;
        if (exp_q.size() == 0) begin
          check_eq("issue_unexpected", 1, 0);
          cur = '{idx: 0, addr: 32'h0, data: 32'h0, strb: 4'h0};
        end else begin
          cur = exp_q.pop_front();
          check_eq("issue_waddr", bus.m_axi_waddr, cur.addr);
          check_eq("issue_wdata", bus.m_axi_wdata, cur.data);
          check_eq("issue_wstrb", bus.m_axi_wstrb, cur.strb);
        end
        if (beh_q.size() != 0) b = beh_q.pop_front();
        else b = '{len: 2, failed: 0, timeout: 0};
        if (b.len == 0) begin
          exp_resp = 2'b11;
          exp_lat  = START_TIMEOUT + 1;
        end else begin
          exp_resp = b.timeout ? 2'b10 : (b.failed ? 2'b01 : 2'b00);
          exp_lat  = b.len + 2;
        end
        issue_cyc  = cyc;
        in_flight  = 1;
        rel        = 0;
        rsp_active = (b.len != 0);
      end else if (rsp_active) begin
        rel++;
        if (rel <= b.len) begin
          bus.m_axi_write_busy = 1'b1;
        end else if (rel == b.len + 1) begin
          bus.m_axi_write_busy    = 1'b0;
          bus.m_axi_write_failed  = b.failed;
          bus.m_axi_write_timeout = b.timeout;
        end else begin
          bus.m_axi_write_failed  = 1'b0;
          bus.m_axi_write_timeout = 1'b0;
          rsp_active = 0;
        end
      end
      if (rst) begin
        in_flight = 0;
      end else if (bus.req_done != '0) begin
        done_count++;
        if (!in_flight) begin
          check_eq("done_unexpected", bus.req_done, 0);
        end else begin
          $display("txn req%0d addr=%08h data=%08h resp=%0d lat=%0d",
                   cur.idx, bus.m_axi_waddr, bus.m_axi_wdata, bus.req_resp, cyc - issue_cyc);
          check_eq("done_onehot", bus.req_done, 64'(1) << cur.idx);
          check_eq("done_resp", bus.req_resp, exp_resp);
          check_eq("done_latency", cyc - issue_cyc, exp_lat);
          check_eq("hold_waddr", bus.m_axi_waddr, cur.addr);
          in_flight = 0;
        end
      end
    end
  end

  task automatic drive_req(input int idx, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit expect_issue, input beh_t b);
    bus.req_write[idx]         = 1'b1;
    bus.req_waddr[idx*32 +: 32] = a;
    bus.req_wdata[idx*32 +: 32] = d;
    bus.req_wstrb[idx*4 +: 4]   = s;
    if (expect_issue) begin
      exp_q.push_back('{idx: idx, addr: a, data: d, strb: s});
      beh_q.push_back(b);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    bus.req_write    = '0;
    bus.overflow_clr = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((bus.req_pending != '0 || bus.arb_active) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", (n < max_cycles), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_write(input int max_cycles);
    int n = 0;
    while (!bus.m_axi_write && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_eq("write_seen", bus.m_axi_write, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ctl"}, {bus.req_pending, bus.req_done, bus.req_resp, bus.req_overflow,
                             bus.m_axi_write, bus.arb_active}, 0);
    check_eq({tag, "_bus"}, {bus.m_axi_waddr, bus.m_axi_wstrb}, 0);
    check_eq({tag, "_data"}, bus.m_axi_wdata, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int dc;
    int wc;
    bus.req_write    = '0;
    bus.req_waddr    = '0;
    bus.req_wdata    = '0;
    bus.req_wstrb    = '0;
    bus.overflow_clr = 1'b0;
    do_reset();

    // Single write with issue latency
    drive_req(0, 32'h4000_1000, 32'hDEAD_BEEF, 4'hF, 1, '{len: 5, failed: 0, timeout: 0});
    next_cycle();
    check_eq("t1_pending_c1", {bus.req_pending, bus.m_axi_write}, {2'b01, 1'b0});
    @(negedge clk);
    check_eq("t1_write_c2", {bus.m_axi_write, bus.arb_active}, 2'b11);
    wait_idle(100);

    // Simultaneous requests, round-robin order
    do_reset();
    drive_req(0, 32'h0000_0100, 32'h1111_0000, 4'h3, 1, '{len: 2, failed: 0, timeout: 0});
    drive_req(1, 32'h0000_0200, 32'h2222_0000, 4'hC, 1, '{len: 1, failed: 0, timeout: 0});
    next_cycle();
    check_eq("t2_both_pending", bus.req_pending, 2'b11);
    wait_idle(200);
    drive_req(0, 32'h0000_0104, 32'h1111_0001, 4'h1, 1, '{len: 3, failed: 0, timeout: 0});
    drive_req(1, 32'h0000_0204, 32'h2222_0001, 4'h8, 1, '{len: 2, failed: 0, timeout: 0});
    next_cycle();
    wait_idle(200);
    drive_req(1, 32'h0000_0208, 32'h2222_0002, 4'hF, 1, '{len: 4, failed: 0, timeout: 0});
    next_cycle();
    wait_write(20);
    next_cycle();
    drive_req(0, 32'h0000_0108, 32'h1111_0002, 4'h6, 1, '{len: 2, failed: 0, timeout: 0});
    next_cycle();
    begin
      int n = 0;
      while (!bus.req_done[1] && n < 40) begin
        @(negedge clk);
        n++;
      end
      check_eq("t2_req1_done", bus.req_done[1], 1);
    end
    drive_req(1, 32'h0000_020C, 32'h2222_0003, 4'h9, 1, '{len: 2, failed: 0, timeout: 0});
    next_cycle();
    wait_idle(200);
    check_eq("t2_no_overflow", bus.req_overflow, 0);

    // Busy never rises
    drive_req(0, 32'h0000_0300, 32'h3333_3333, 4'hF, 1, '{len: 0, failed: 0, timeout: 0});
    next_cycle();
    wc = write_count;
    wait_idle(100);
    check_eq("t3_single_issue", write_count - wc, 1);

    // Error responses
    drive_req(0, 32'h0000_0400, 32'h4444_0000, 4'hF, 1, '{len: 3, failed: 1, timeout: 0});
    next_cycle();
    wait_idle(100);
    drive_req(1, 32'h0000_0404, 32'h4444_0001, 4'hF, 1, '{len: 3, failed: 1, timeout: 1});
    next_cycle();
    wait_idle(100);

    // Overflow, clear, and strobe landing in the completion cycle
    drive_req(0, 32'h0000_0500, 32'h5555_0000, 4'hF, 1, '{len: 8, failed: 0, timeout: 0});
    next_cycle();
    wait_write(20);
    next_cycle();
    drive_req(0, 32'h0000_0BAD, 32'hBAD0_BAD0, 4'h1, 0, '{len: 0, failed: 0, timeout: 0});
    next_cycle();
    check_eq("t5_overflow_set", bus.req_overflow, 2'b01);
    bus.overflow_clr = 1'b1;
    next_cycle();
    check_eq("t5_overflow_clr", bus.req_overflow, 2'b00);
    repeat (6) @(negedge clk);
    drive_req(0, 32'h0000_0504, 32'h5555_0001, 4'h7, 1, '{len: 2, failed: 0, timeout: 0});
    next_cycle();
    check_eq("t5_done_and_pending", {bus.req_done, bus.req_pending}, {2'b01, 2'b01});
    check_eq("t5_no_overflow", bus.req_overflow, 2'b00);
    wait_idle(100);

    // Reset while waiting for busy to fall
    drive_req(1, 32'h0000_0600, 32'h6666_0000, 4'hF, 1, '{len: 10, failed: 0, timeout: 0});
    next_cycle();
    wait_write(20);
    repeat (3) @(negedge clk);
    check_eq("t6_in_flight", bus.arb_active, 1);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("t6_after_reset");
    @(negedge clk);
    rst = 1'b0;
    dc = done_count;
    repeat (20) @(negedge clk);
    check_eq("t6_no_done", done_count - dc, 0);
    check_eq("t6_idle", {bus.req_pending, bus.arb_active}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
